// File: rtl/button_scan.sv
// Debounced button scanner: 2-flop sync, shared tick prescaler, per-button debounce.
// Optional auto-repeat when BUTTON_SCAN_REPEAT_EN is defined; otherwise REPEAT is 0.
module button_scan #(
    parameter int NUM_BUTTONS    = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic                   OSC_50M,
    input  logic                   RST_N,
    input  logic [NUM_BUTTONS-1:0] BUTTON,
    output logic [NUM_BUTTONS-1:0] PRESSED,
    output logic [NUM_BUTTONS-1:0] PRESS,
    output logic [NUM_BUTTONS-1:0] RELEASE,
    output logic [NUM_BUTTONS-1:0] REPEAT
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [NUM_BUTTONS-1:0] IDLE =
        (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] sample;
    logic [PW-1:0]          pcnt;
    logic                   tick;

    always_ff @(posedge OSC_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= BUTTON;
            sync2 <= sync1;
        end
    end

    assign sample = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge OSC_50M or negedge RST_N) begin
        if (!RST_N) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = (pcnt == PMAX);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        logic [DW-1:0] cnt;
        logic          held;
        logic          prs;
        logic          rel;
        logic          differ;
        logic          decide;

        assign differ = sample[i] ^ held;
        assign decide = tick && differ && (cnt == DLAST);

        always_ff @(posedge OSC_50M or negedge RST_N) begin
            if (!RST_N) begin
                cnt  <= '0;
                held <= 1'b0;
                prs  <= 1'b0;
                rel  <= 1'b0;
            end else begin
                prs <= 1'b0;
                rel <= 1'b0;
                if (tick) begin
                    if (!differ) begin
                        cnt <= '0;
                    end else if (decide) begin
                        cnt  <= '0;
                        held <= sample[i];
                        prs  <= sample[i];
                        rel  <= ~sample[i];
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
            end
        end

        assign PRESSED[i] = held;
        assign PRESS[i]   = prs;
        assign RELEASE[i] = rel;

`ifdef BUTTON_SCAN_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                              REPEAT_DELAY : REPEAT_RATE;
        localparam int RW = $clog2(RMAX + 1);
        localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
        localparam logic [RW-1:0] RRTE = RW'(REPEAT_RATE);

        logic [RW-1:0] rcnt;
        logic          rep;

        // A deciding tick never repeats: press loads, release clears.
        always_ff @(posedge OSC_50M or negedge RST_N) begin
            if (!RST_N) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else begin
                rep <= 1'b0;
                if (decide && !held) begin
                    rcnt <= RDLY;
                end else if (decide && held) begin
                    rcnt <= '0;
                end else if (tick && held) begin
                    if (rcnt == RW'(1)) begin
                        rep  <= 1'b1;
                        rcnt <= RRTE;
                    end else begin
                        rcnt <= rcnt - RW'(1);
                    end
                end
            end
        end

        assign REPEAT[i] = rep;
`else
        assign REPEAT[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_scan.sv
// Self-checking bench for button_scan: vector table, directed repeat, random stimulus.
// Reference model tracks sample runs and ticks-since-press arithmetically.
module tb_button_scan;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic         clk = 1'b0;
    logic         RST_N;
    logic [N-1:0] BUTTON;
    logic [N-1:0] PRESSED;
    logic [N-1:0] PRESS;
    logic [N-1:0] RELEASE;
    logic [N-1:0] REPEAT;

    button_scan #(
        .NUM_BUTTONS    (N),
        .ACTIVE_LOW     (1),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .OSC_50M (clk),
        .RST_N   (RST_N),
        .BUTTON  (BUTTON),
        .PRESSED (PRESSED),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .REPEAT  (REPEAT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_p1, m_p2, m_state, m_press, m_rel, m_rep;
    int           m_n;
    int           m_run [N];
    int           m_k   [N];

    typedef struct {
        logic [N-1:0] b;
        logic         rst;
        int           ncyc;
        logic [N-1:0] pressed;
        logic [N-1:0] por;
        logic [N-1:0] ror;
        int           evc;
    } vec_t;

    vec_t vecs [21];

    logic [N-1:0] seg_por, seg_ror;
    int           seg_evc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = '1;
        m_p2 = '1;
        m_state = '0;
        m_press = '0;
        m_rel = '0;
        m_rep = '0;
        m_n = 0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_k[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] pin);
        logic         tk;
        logic [N-1:0] smp;
        tk = (m_n % TD) == TD - 1;
        m_n++;
        smp = ~m_p2;
        m_p2 = m_p1;
        m_p1 = pin;
        m_press = '0;
        m_rel = '0;
        m_rep = '0;
        if (tk) begin
            for (int i = 0; i < N; i++) begin
                if (smp[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_state[i] = smp[i];
                        m_run[i] = 0;
                        if (smp[i]) begin
                            m_press[i] = 1'b1;
                            m_k[i] = 0;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
`ifdef BUTTON_SCAN_REPEAT_EN
                if (m_state[i] && !m_press[i]) begin
                    m_k[i]++;
                    if (m_k[i] == RD ||
                        (m_k[i] > RD && (m_k[i] - RD) % RR == 0))
                        m_rep[i] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] b, input logic r);
        BUTTON = b;
        RST_N = r;
        if (!r) model_reset();
        @(posedge clk);
        if (r) model_step(b);
        @(negedge clk);
        check("outputs", {16'h0, PRESSED, PRESS, RELEASE, REPEAT},
              {16'h0, m_state, m_press, m_rel, m_rep});
        check("press_release_overlap", {28'h0, PRESS & RELEASE}, 32'h0);
        seg_por |= PRESS;
        seg_ror |= RELEASE;
        if ((PRESS | RELEASE) != '0) seg_evc++;
    endtask

    task automatic run_seg(input vec_t v, input int idx);
        seg_por = '0;
        seg_ror = '0;
        seg_evc = 0;
        for (int c = 0; c < v.ncyc; c++) cycle(v.b, v.rst);
        check($sformatf("vec%0d_pressed", idx), {28'h0, PRESSED},
              {28'h0, v.pressed});
        check($sformatf("vec%0d_press", idx), {28'h0, seg_por},
              {28'h0, v.por});
        check($sformatf("vec%0d_release", idx), {28'h0, seg_ror},
              {28'h0, v.ror});
        check($sformatf("vec%0d_events", idx), seg_evc, v.evc);
    endtask

    initial begin
        logic [N-1:0] rb;
        int           cnt;
        int           w;

        vecs[0]  = '{4'hF, 1'b0, 3,   4'h0, 4'h0, 4'h0, 0};
        vecs[1]  = '{4'hF, 1'b1, 100, 4'h0, 4'h0, 4'h0, 0};
        vecs[2]  = '{4'hE, 1'b1, 15,  4'h1, 4'h1, 4'h0, 1};
        vecs[3]  = '{4'hF, 1'b1, 15,  4'h0, 4'h0, 4'h1, 1};
        for (int i = 0; i < 5; i++) begin
            vecs[4 + 2 * i] = '{4'hD, 1'b1, 8, 4'h0, 4'h0, 4'h0, 0};
            vecs[5 + 2 * i] = '{4'hF, 1'b1, 4, 4'h0, 4'h0, 4'h0, 0};
        end
        vecs[14] = '{4'hF, 1'b1, 20,  4'h0, 4'h0, 4'h0, 0};
        vecs[15] = '{4'h3, 1'b1, 15,  4'hC, 4'hC, 4'h0, 1};
        vecs[16] = '{4'hF, 1'b1, 15,  4'h0, 4'h0, 4'hC, 1};
        vecs[17] = '{4'hE, 1'b1, 15,  4'h1, 4'h1, 4'h0, 1};
        vecs[18] = '{4'hE, 1'b0, 1,   4'h0, 4'h0, 4'h0, 0};
        vecs[19] = '{4'hE, 1'b1, 15,  4'h1, 4'h1, 4'h0, 1};
        vecs[20] = '{4'hF, 1'b1, 15,  4'h0, 4'h0, 4'h1, 1};

        BUTTON = 4'hF;
        RST_N = 1'b0;
        model_reset();

        for (int i = 0; i < 21; i++) run_seg(vecs[i], i);

`ifdef BUTTON_SCAN_REPEAT_EN
        w = 0;
        cycle(4'hE, 1'b1);
        while (!PRESS[0] && w < 20) begin
            cycle(4'hE, 1'b1);
            w++;
        end
        check("repeat_press_seen", {31'h0, PRESS[0]}, 32'h1);
        cnt = 0;
        for (int c = 0; c < 48; c++) begin
            cycle(4'hE, 1'b1);
            if (REPEAT[0]) cnt++;
        end
        check("repeat_count_held", cnt, 4);
        w = 0;
        cycle(4'hF, 1'b1);
        while (!RELEASE[0] && w < 20) begin
            cycle(4'hF, 1'b1);
            w++;
        end
        check("repeat_release_seen", {31'h0, RELEASE[0]}, 32'h1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(4'hF, 1'b1);
            if (REPEAT[0]) cnt++;
        end
        check("repeat_count_released", cnt, 0);
`endif

        rb = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) rb[$urandom_range(N - 1)] ^= 1'b1;
            cycle(rb, ($urandom_range(999) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
